// File: rtl/conv1_window_mac_if.sv
// Column-beat, kernel-load and output-pixel signals of the conv1 window MAC.
// The master side drives beats and loads; the slave side returns pixels.
interface conv1_window_mac_if #(
   parameter int DATA_WIDTH = 8,
   parameter int W_WIDTH    = 8,
   parameter int B_WIDTH    = 16
);
   logic                  new_filter;
   logic                  col_valid;
   logic [DATA_WIDTH-1:0] col_top;
   logic [DATA_WIDTH-1:0] col_mid;
   logic [DATA_WIDTH-1:0] col_bot;
   logic                  w_load;
   logic [3:0]            w_idx;
   logic [W_WIDTH-1:0]    w_data;
   logic                  b_load;
   logic [B_WIDTH-1:0]    b_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      output new_filter, col_valid, col_top, col_mid, col_bot,
      output w_load, w_idx, w_data, b_load, b_data,
      input  out_valid, out_data, out_last
   );

   modport slave (
      input  new_filter, col_valid, col_top, col_mid, col_bot,
      input  w_load, w_idx, w_data, b_load, b_data,
      output out_valid, out_data, out_last
   );
endinterface

// File: rtl/conv1_window_mac.sv
// 3x3 sliding-window convolution: builds windows from column beats, then
// multiply / sum+bias / ReLU-shift-saturate over three pipeline stages.
module conv1_window_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int W_WIDTH    = 8,
   parameter int B_WIDTH    = 16,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int OUT_SHIFT  = 7
) (
   input  logic               clk,
   input  logic               resetn,
   conv1_window_mac_if.slave  bus
);
   localparam int PW   = DATA_WIDTH + W_WIDTH + 1;
   localparam int SW   = PW + 4;
   localparam int AW   = SW + 1;
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H - 2);
   localparam int MAXV = (1 << DATA_WIDTH) - 1;

   logic [CW-1:0]                col_cnt_reg;
   logic [RW-1:0]                row_cnt_reg;
   logic [DATA_WIDTH-1:0]        win_reg [0:2][0:2];
   logic                         launch_reg, launch_last_reg;
   logic signed [W_WIDTH-1:0]    w_reg [0:8];
   logic signed [B_WIDTH-1:0]    b_reg;
   logic signed [PW-1:0]         prod_next [0:8];
   logic signed [PW-1:0]         prod_reg [0:8];
   logic                         s1_valid_reg, s1_last_reg, s2_valid_reg, s2_last_reg;
   logic signed [SW-1:0]         sum_next;
   logic signed [AW-1:0]         acc_next, acc_reg;
   logic [AW-1:0]                shifted;
   logic [DATA_WIDTH-1:0]        pix_next;
   logic                         col_last, row_last;

   assign col_last = (col_cnt_reg == CW'(IMG_W - 1));
   assign row_last = (row_cnt_reg == RW'(IMG_H - 3));

   // Window and counters; a launch is flagged once two columns already sit in the window.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn || bus.new_filter) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_reg[r][c] <= '0;
         col_cnt_reg     <= '0;
         row_cnt_reg     <= '0;
         launch_reg      <= 1'b0;
         launch_last_reg <= 1'b0;
      end else begin
         launch_reg      <= bus.col_valid && (col_cnt_reg >= CW'(2));
         launch_last_reg <= bus.col_valid && col_last && row_last;
         if (bus.col_valid) begin
            for (int r = 0; r < 3; r++) begin
               win_reg[r][0] <= win_reg[r][1];
               win_reg[r][1] <= win_reg[r][2];
            end
            win_reg[0][2] <= bus.col_top;
            win_reg[1][2] <= bus.col_mid;
            win_reg[2][2] <= bus.col_bot;
            if (col_last) begin
               col_cnt_reg <= '0;
               row_cnt_reg <= row_last ? '0 : row_cnt_reg + RW'(1);
            end else begin
               col_cnt_reg <= col_cnt_reg + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < 9; k++)
            w_reg[k] <= '0;
         b_reg <= '0;
      end else begin
         if (bus.w_load && (bus.w_idx <= 4'd8))
            w_reg[bus.w_idx] <= bus.w_data;
         if (bus.b_load)
            b_reg <= bus.b_data;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_mul
         // Pixel is unsigned: zero-extend before the signed multiply.
         assign prod_next[gi] = PW'($signed({1'b0, win_reg[gi / 3][gi % 3]})) * PW'(w_reg[gi]);
      end
   endgenerate

   always_comb begin
      sum_next = '0;
      for (int k = 0; k < 9; k++)
         sum_next = sum_next + SW'(prod_reg[k]);
      acc_next = AW'(sum_next) + AW'(b_reg);
   end

   always_comb begin
      shifted = '0;
      if (!acc_reg[AW-1])
         shifted = $unsigned(acc_reg) >> OUT_SHIFT;
      pix_next = (shifted > AW'(MAXV)) ? DATA_WIDTH'(MAXV) : shifted[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < 9; k++)
            prod_reg[k] <= '0;
         acc_reg <= '0;
      end else begin
         if (launch_reg)
            for (int k = 0; k < 9; k++)
               prod_reg[k] <= prod_next[k];
         if (s1_valid_reg)
            acc_reg <= acc_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn || bus.new_filter) begin
         s1_valid_reg  <= 1'b0;
         s1_last_reg   <= 1'b0;
         s2_valid_reg  <= 1'b0;
         s2_last_reg   <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         s1_valid_reg  <= launch_reg;
         s1_last_reg   <= launch_last_reg;
         s2_valid_reg  <= s1_valid_reg;
         s2_last_reg   <= s1_last_reg;
         bus.out_valid <= s2_valid_reg;
         bus.out_last  <= s2_valid_reg && s2_last_reg;
         bus.out_data  <= s2_valid_reg ? pix_next : '0;
      end
   end
endmodule

// File: doc/conv1_window_mac.md
Name: conv1_window_mac

Overview:
Downstream consumer of the conv1 line buffer. Each accepted beat carries one 3-pixel column of three consecutive image rows (top, middle, bottom). The block assembles 3x3 windows by shifting columns and multiplies each window by a loaded 3x3 signed kernel. It adds a bias, applies ReLU and requantizes to 8 bits, producing a 26x26 feature map per filter for the pooling stage.

Parameters:
DATA_WIDTH, 8, pixel width (unsigned) and output width
W_WIDTH, 8, kernel weight width (signed, two's complement)
B_WIDTH, 16, bias width (signed)
IMG_W, 28, input row length in columns
IMG_H, 28, input image height
OUT_SHIFT, 7, arithmetic right shift applied after ReLU

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
new_filter  in  1  synchronous flush: counters, window, pipeline cleared
col_valid  in  1  column beat strobe (line buffer data_rdy)
col_top  in  DATA_WIDTH  oldest row pixel
col_mid  in  DATA_WIDTH  middle row pixel
col_bot  in  DATA_WIDTH  newest row pixel
w_load  in  1  write w_data to kernel slot w_idx
w_idx  in  4  kernel slot, r*3+c, r=0 top row, c=0 leftmost column
w_data  in  W_WIDTH  weight value
b_load  in  1  write b_data to bias register
b_data  in  B_WIDTH  bias value
out_valid  out  1  output pixel strobe
out_data  out  DATA_WIDTH  output pixel
out_last  out  1  high with final pixel (row 25, col 25) of a frame

Behaviour:
- Clock clk; reset is asynchronous, active-low on resetn. Reset clears all outputs, counters, window registers, pipeline valids, weights and bias to 0.
- Window: 3x3 register array. On col_valid, columns shift left and the new column enters at c=2. Column counter col_cnt (0..IMG_W-1) increments and wraps to 0 after IMG_W-1. Row counter row_cnt (0..IMG_H-3) increments on that wrap.
- Window launch: if col_valid and col_cnt >= 2 (pre-increment value), the window including the incoming column issues into the pipeline. This yields IMG_W-2 = 26 launches per row. Beats at col_cnt 0 and 1 only fill the window. Windows never straddle rows.
- Pipeline, 3 stages; out_valid asserts 3 cycles after the launching col_valid edge. No backpressure; gaps in col_valid are allowed.
  - S1: 9 products, unsigned 8b pixel times signed 8b weight, each 17b signed.
  - S2: signed sum of products, 21b, plus sign-extended bias, 22b.
  - S3: ReLU (negative gives 0), then >> OUT_SHIFT, then saturate to 255. Result registers to out_data.
- When out_valid=0, out_data=0 and out_last=0.
- out_last: asserts with the launch at row_cnt=IMG_H-3, col_cnt=IMG_W-1, delayed with the pipeline. Counters then wrap to 0,0.
- new_filter: same-cycle priority over col_valid. It clears col_cnt, row_cnt, the window and all stage valids, so in-flight results are dropped and no out_valid occurs for them. It does not clear weights or bias.
- w_load/b_load: take effect on the next edge and are independent of col_valid. Launches after the edge use the new value. The controller loads only between frames. If w_idx > 8, the write is ignored.
- Simultaneous w_load and b_load both apply.
- Reset mid-frame: everything returns to the reset state. The next frame starts from col_cnt=0.

Test Plan:
- Identity kernel (w[4]=1, others 0), bias 0, OUT_SHIFT=0, image pixel(r,c)=(r+c)&0xFF -> 676 outputs, out(i,j)=(i+1)+(j+1), out_last only on the 676th, each out_valid 3 cycles after its launch.
- All weights +127, all pixels 255, bias 0, OUT_SHIFT=7 -> sum 291465, >>7 = 2277, saturated to 255 for every output.
- All weights -1, pixels 10, bias +100, OUT_SHIFT=0 -> -90+100=10 on every output. Bias -100 -> ReLU gives 0.
- col_valid with random 0-3 cycle gaps, identity kernel -> output sequence identical to the gap-free run; no out_valid at col_cnt 0 or 1 of any row.
- new_filter asserted mid-row 5 while 2 results are in flight -> those 2 are never emitted; next frame's first output appears after col_cnt reaches 2, with counters at 0.
- resetn pulsed low mid-frame -> out_valid, out_data, out_last go 0 immediately and asynchronously. Weights read back as 0, so with bias 0 the next frame outputs all zeros.
